round_tracker: RTL and testbench

- Sequential score keeper for one game. Accepts one result per round from the round judge and maintains binary round/win/lose counters.
- Drives those counters into isfinish, then samples isfinish's fin/printwinner one cycle later to decide whether play continues.
- Latches the final winner code and holds it until the next game starts.

---
 rtl/round_tracker_pkg.sv | 23 ++
 rtl/round_tracker_sat_counter.sv | 26 ++
 rtl/round_tracker.sv | 117 +++++++++++
 tb/tb_round_tracker.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/round_tracker_pkg.sv
// Shared definitions for the game score keeper: round-result and winner
// encodings plus the tracker state enumeration.
package round_tracker_pkg;

  // Round result, player-1 view (11 is illegal)
  localparam logic [1:0] RES_DRAW = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;

  // Winner code, same encoding as isfinish printwinner
  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_DRAW = 2'b01;
  localparam logic [1:0] W_P1   = 2'b10;
  localparam logic [1:0] W_P2   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/round_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : increment by one, holding at all-ones
//   cnt        : registered count
module sat_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/round_tracker.sv
// Score keeper for one game. Accepts one round result at a time, updates
// round/win/lose counters, then samples the external isfinish verdict in a
// one-cycle EVAL state to decide whether play continues. The final winner is
// latched and held until the next start.
//   clk, rst_n         : clock, async active-low reset
//   start              : begin / restart a game, clears counters and winner
//   res_valid, res     : round result offer; res_ready high only in PLAY
//   round, win, lose   : registered counters, driven to isfinish
//   fin, printwinner   : isfinish verdict, sampled during EVAL
//   game_over, winner  : registered end-of-game status
//   res_err            : one-cycle pulse after an illegal result in PLAY
module round_tracker
  import round_tracker_pkg::*;
#(
  parameter int unsigned CW        = 4,
  parameter int unsigned MAX_ROUND = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          res_valid,
  input  logic [1:0]    res,
  output logic          res_ready,
  output logic [CW-1:0] round,
  output logic [CW-1:0] win,
  output logic [CW-1:0] lose,
  input  logic          fin,
  input  logic [1:0]    printwinner,
  output logic          game_over,
  output logic [1:0]    winner,
  output logic          res_err
);

  // Round cap must be representable in the counters
  if (MAX_ROUND >= (2 ** CW)) begin : g_bad_max_round
    $error("round_tracker: MAX_ROUND must be < 2**CW");
  end

  localparam logic [CW-1:0] ROUND_CAP = CW'(MAX_ROUND);

  state_t     state, state_d;
  logic [1:0] winner_d;
  logic       clr, inc_round, inc_win, inc_lose, err_d;

  // State register and registered outputs (decoded from the next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      winner    <= W_NONE;
      res_ready <= 1'b0;
      game_over <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_d;
      winner    <= winner_d;
      res_ready <= (state_d == S_PLAY);
      game_over <= (state_d == S_DONE);
      res_err   <= err_d;
    end
  end

  // Next-state and counter control; start overrides everything else
  always_comb begin
    state_d   = state;
    winner_d  = winner;
    clr       = 1'b0;
    inc_round = 1'b0;
    inc_win   = 1'b0;
    inc_lose  = 1'b0;
    err_d     = 1'b0;
    if (start) begin
      clr      = 1'b1;
      winner_d = W_NONE;
      state_d  = S_PLAY;
    end else begin
      case (state)
        S_PLAY: begin
          if (res_valid) begin
            if (res == 2'b11) begin
              err_d = 1'b1;
            end else begin
              inc_round = 1'b1;
              inc_win   = (res == RES_WIN);
              inc_lose  = (res == RES_LOSE);
              state_d   = S_EVAL;
            end
          end
        end
        S_EVAL: begin
          if (fin) begin
            winner_d = printwinner;
            state_d  = S_DONE;
          end else if (round == ROUND_CAP) begin
            winner_d = W_DRAW;
            state_d  = S_DONE;
          end else begin
            state_d = S_PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CW(CW)) u_round (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(inc_round), .cnt(round)
  );

  sat_counter #(.CW(CW)) u_win (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(inc_win), .cnt(win)
  );

  sat_counter #(.CW(CW)) u_lose (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(inc_lose), .cnt(lose)
  );

endmodule

// File: tb/tb_round_tracker.sv
// Directed bench for round_tracker; the isfinish block is stubbed by driving
// fin/printwinner directly.
module tb_round_tracker;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          res_valid;
  logic [1:0]    res;
  logic          res_ready;
  logic [CW-1:0] round, win, lose;
  logic          fin;
  logic [1:0]    printwinner;
  logic          game_over;
  logic [1:0]    winner;
  logic          res_err;

  int n_pass  = 0;
  int n_total = 0;

  round_tracker #(.CW(CW), .MAX_ROUND(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid),
    .res(res), .res_ready(res_ready), .round(round), .win(win),
    .lose(lose), .fin(fin), .printwinner(printwinner),
    .game_over(game_over), .winner(winner), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; res_valid = 1'b0; res = 2'b00;
    fin = 1'b0; printwinner = 2'b00;

    // Reset then idle
    repeat (3) step();
    rst_n = 1'b1;
    step(); step();
    check("idle_round",     32'(round),     32'd0);
    check("idle_win",       32'(win),       32'd0);
    check("idle_lose",      32'(lose),      32'd0);
    check("idle_ready",     32'(res_ready), 32'd0);
    check("idle_winner",    32'(winner),    32'd0);
    check("idle_game_over", 32'(game_over), 32'd0);
    check("idle_res_err",   32'(res_err),   32'd0);

    // Normal accept
    start = 1'b1; step(); start = 1'b0;
    check("play_ready", 32'(res_ready), 32'd1);
    res_valid = 1'b1; res = 2'b01; step(); res_valid = 1'b0;
    check("acc_round", 32'(round),     32'd1);
    check("acc_win",   32'(win),       32'd1);
    check("acc_lose",  32'(lose),      32'd0);
    check("eval_ready", 32'(res_ready), 32'd0);
    step();
    check("back_ready", 32'(res_ready), 32'd1);
    check("back_go",    32'(game_over), 32'd0);

    // End by isfinish, p2 wins
    res_valid = 1'b1; res = 2'b10; step(); res_valid = 1'b0;
    fin = 1'b1; printwinner = 2'b11; step();
    fin = 1'b0; printwinner = 2'b00;
    check("fin_go",     32'(game_over), 32'd1);
    check("fin_winner", 32'(winner),    32'd3);
    check("fin_round",  32'(round),     32'd2);
    check("fin_lose",   32'(lose),      32'd1);
    res_valid = 1'b1; res = 2'b01; step(); step(); res_valid = 1'b0;
    check("done_round",  32'(round),     32'd2);
    check("done_win",    32'(win),       32'd1);
    check("done_ready",  32'(res_ready), 32'd0);
    check("done_winner", 32'(winner),    32'd3);

    // Round cap: nine draws
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      res_valid = 1'b1; res = 2'b00; step(); res_valid = 1'b0;
      step();
      if (i == 7) check("cap_r8_go", 32'(game_over), 32'd0);
    end
    check("cap_round",  32'(round),     32'd9);
    check("cap_win",    32'(win),       32'd0);
    check("cap_lose",   32'(lose),      32'd0);
    check("cap_go",     32'(game_over), 32'd1);
    check("cap_winner", 32'(winner),    32'd1);

    // Illegal result
    start = 1'b1; step(); start = 1'b0;
    res_valid = 1'b1; res = 2'b11; step(); res_valid = 1'b0;
    check("ill_err",   32'(res_err),   32'd1);
    check("ill_round", 32'(round),     32'd0);
    check("ill_ready", 32'(res_ready), 32'd1);
    step();
    check("ill_err_clr", 32'(res_err), 32'd0);

    // start beats a same-cycle result
    start = 1'b1; res_valid = 1'b1; res = 2'b01; step();
    start = 1'b0; res_valid = 1'b0;
    check("pri_round", 32'(round),     32'd0);
    check("pri_win",   32'(win),       32'd0);
    check("pri_ready", 32'(res_ready), 32'd1);

    // Restart from EVAL
    res_valid = 1'b1; res = 2'b01; step(); res_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check("reval_round", 32'(round),     32'd0);
    check("reval_ready", 32'(res_ready), 32'd1);

    // P1 wins, then restart from DONE
    res_valid = 1'b1; res = 2'b01; step(); res_valid = 1'b0;
    fin = 1'b1; printwinner = 2'b10; step();
    fin = 1'b0; printwinner = 2'b00;
    check("p1_winner", 32'(winner),    32'd2);
    check("p1_go",     32'(game_over), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    check("rs_winner", 32'(winner),    32'd0);
    check("rs_round",  32'(round),     32'd0);
    check("rs_win",    32'(win),       32'd0);
    check("rs_ready",  32'(res_ready), 32'd1);
    check("rs_go",     32'(game_over), 32'd0);

    // Async reset during EVAL
    res_valid = 1'b1; res = 2'b01; step(); res_valid = 1'b0;
    check("ar_pre_win", 32'(win), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_round",  32'(round),     32'd0);
    check("ar_win",    32'(win),       32'd0);
    check("ar_ready",  32'(res_ready), 32'd0);
    check("ar_winner", 32'(winner),    32'd0);
    check("ar_go",     32'(game_over), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_idle_ready", 32'(res_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
